// File: rtl/instr_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instr_fetch_stage                                      |
// | Description : Pipeline front end. Holds the PC, drives the memory    |
// |               address, and registers the fetched word for the        |
// |               decoder through a valid/ready handshake.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module instr_fetch_stage #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Run,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [ADDR_W-1:0] A,
  input  logic [31:0]       RD,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] InstrPC,
  output logic [ADDR_W-1:0] PCPlus8,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic              AlignErr
);

  localparam logic [ADDR_W-1:0] c_step  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] c_eight = ADDR_W'(8);

  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;
  logic              r_align_err;

  logic              w_load;
  logic              w_fire;
  logic [ADDR_W-1:0] w_target;

  // A new word may be captured when fetching is enabled and the output slot is free or being emptied.
  always_comb begin
    w_load   = Run & (~r_valid | InstrReady);
    w_fire   = r_valid & InstrReady;
    w_target = {BranchTarget[ADDR_W-1:2], 2'b00};
  end

  // PC, fetch/decode register and status: redirect beats fetch beats drain; otherwise hold (stall).
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc        <= RESET_PC;
      r_instr     <= 32'h0;
      r_instr_pc  <= '0;
      r_valid     <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= BranchTaken & (|BranchTarget[1:0]);
      if (BranchTaken) begin
        // Flush the held word; Instr/InstrPC keep stale contents qualified by valid.
        r_pc    <= w_target;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_instr    <= RD;
        r_instr_pc <= r_pc;
        r_valid    <= 1'b1;
        r_pc       <= r_pc + c_step;
      end else if (w_fire) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Outputs: address is the live PC, PCPlus8 is the architectural PC-read value.
  always_comb begin
    A          = r_pc;
    Instr      = r_instr;
    InstrPC    = r_instr_pc;
    PCPlus8    = r_instr_pc + c_eight;
    InstrValid = r_valid;
    AlignErr   = r_align_err;
  end

endmodule
`default_nettype wire
